// File: rtl/ddr4_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_bank_scheduler
// Brief    : One-request-in-flight DDR4 command scheduler with open-row table,
//            tCCD spacing and periodic refresh.
// Revision : 1.0
// ============================================================================
module ddr4_bank_scheduler #(
    parameter int ADDR_W  = 32,
    parameter int BA_W    = 2,
    parameter int BG_W    = 2,
    parameter int COL_W   = 8,
    parameter int ROW_W   = 14,
    parameter int T_RP    = 16,
    parameter int T_RCD   = 16,
    parameter int T_CL    = 16,
    parameter int T_CWL   = 12,
    parameter int T_BURST = 4,
    parameter int T_CCD_S = 4,
    parameter int T_CCD_L = 6,
    parameter int T_REFI  = 7800,
    parameter int T_RFC   = 350
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_valid,
    output logic [2:0]        cmd,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              done,
    output logic              page_hit
);

    localparam int c_IDX_W  = BA_W + BG_W;
    localparam int c_NB     = 1 << c_IDX_W;
    localparam int c_USED_W = 6 + BA_W + BG_W + COL_W + ROW_W;
    localparam int c_M1     = (T_REFI > T_RFC) ? T_REFI : T_RFC;
    localparam int c_M2     = (T_CL > T_CWL) ? T_CL + T_BURST : T_CWL + T_BURST;
    localparam int c_M3     = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int c_TMAX   = (c_M1 > c_M2) ? ((c_M1 > c_M3) ? c_M1 : c_M3)
                                            : ((c_M2 > c_M3) ? c_M2 : c_M3);
    localparam int c_TIM_W  = $clog2(c_TMAX + 1) + 1;

    localparam logic [2:0] c_CMD_NOP  = 3'd0;
    localparam logic [2:0] c_CMD_ACT  = 3'd1;
    localparam logic [2:0] c_CMD_PRE  = 3'd2;
    localparam logic [2:0] c_CMD_RD   = 3'd3;
    localparam logic [2:0] c_CMD_WR   = 3'd4;
    localparam logic [2:0] c_CMD_REF  = 3'd5;
    localparam logic [2:0] c_CMD_PREA = 3'd6;

    typedef enum logic [2:0] {IDLE, PRE, ACT, COL, DATA, PREA, REF} state_t;

    state_t               r_state, w_state_nxt;
    logic [c_TIM_W-1:0]   r_timer, w_timer_nxt;
    logic [c_TIM_W-1:0]   r_refi_cnt;
    logic                 r_ref_pending, w_pend_nxt, w_expire, w_ref_clear;
    logic [7:0]           r_ccd_cnt, w_ccd_need;
    logic                 w_ccd_ok;
    logic [BG_W-1:0]      r_last_bg;
    logic [c_NB-1:0]      r_tbl_valid;
    logic [ROW_W-1:0]     r_tbl_row [c_NB];

    logic [1:0]           r_op;
    logic [BG_W-1:0]      r_bg;
    logic [BA_W-1:0]      r_ba;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic                 r_hit;

    logic [BG_W-1:0]      w_req_bg, w_cur_bg;
    logic [BA_W-1:0]      w_req_ba, w_cur_ba;
    logic [ROW_W-1:0]     w_req_row, w_cur_row;
    logic [COL_W-1:0]     w_req_col, w_cur_col;
    logic [c_IDX_W-1:0]   w_req_idx, w_cur_idx;
    logic                 w_req_hit, w_cur_rd;

    logic                 r_req_ready, w_ready_nxt;
    logic                 r_cmd_valid, w_cmd_valid_nxt;
    logic [2:0]           r_cmd, w_cmd_nxt;
    logic [BG_W-1:0]      r_cmd_bg, w_bg_nxt;
    logic [BA_W-1:0]      r_cmd_ba, w_ba_nxt;
    logic [ROW_W-1:0]     r_cmd_row, w_row_nxt;
    logic [COL_W-1:0]     r_cmd_col, w_col_nxt;
    logic                 r_done, w_done_nxt, r_page_hit, w_hit_nxt;
    logic                 w_accept, w_col_go, w_act_go, w_tbl_clr;

    // Address layout, LSB up: 6 unused bits, bank, group, column, row
    assign w_req_ba  = req_addr[6 +: BA_W];
    assign w_req_bg  = req_addr[6 + BA_W +: BG_W];
    assign w_req_col = req_addr[6 + BA_W + BG_W +: COL_W];
    assign w_req_row = req_addr[6 + BA_W + BG_W + COL_W +: ROW_W];
    assign w_req_idx = {w_req_bg, w_req_ba};
    assign w_req_hit = r_tbl_valid[w_req_idx] && (r_tbl_row[w_req_idx] == w_req_row);

    logic w_unused_lo;
    assign w_unused_lo = ^req_addr[5:0];

    generate
        if (ADDR_W > c_USED_W) begin : g_addr_pad
            logic w_unused_hi;
            assign w_unused_hi = ^req_addr[ADDR_W-1:c_USED_W];
        end
    endgenerate

    // In IDLE the live request drives the command fields; afterwards the latched copy
    assign w_cur_bg  = (r_state == IDLE) ? w_req_bg  : r_bg;
    assign w_cur_ba  = (r_state == IDLE) ? w_req_ba  : r_ba;
    assign w_cur_row = (r_state == IDLE) ? w_req_row : r_row;
    assign w_cur_col = (r_state == IDLE) ? w_req_col : r_col;
    assign w_cur_rd  = (r_state == IDLE) ? (req_op != 2'd1) : (r_op != 2'd1);
    assign w_cur_idx = {w_cur_bg, w_cur_ba};

    // Tracker holds cycles since the last column command; a new one lands next cycle
    assign w_ccd_need = (w_cur_bg == r_last_bg) ? 8'(T_CCD_L - 1) : 8'(T_CCD_S - 1);
    assign w_ccd_ok   = (r_ccd_cnt >= w_ccd_need);

    assign w_expire    = (r_refi_cnt == c_TIM_W'(T_REFI - 1));
    assign w_pend_nxt  = (r_ref_pending && !w_ref_clear) || (w_expire && !r_ref_pending);
    assign w_ready_nxt = (w_state_nxt == IDLE) && !w_pend_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = (r_timer != '0) ? r_timer - 1'b1 : '0;
        w_accept        = 1'b0;
        w_col_go        = 1'b0;
        w_act_go        = 1'b0;
        w_tbl_clr       = 1'b0;
        w_ref_clear     = 1'b0;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_nxt       = c_CMD_NOP;
        w_bg_nxt        = '0;
        w_ba_nxt        = '0;
        w_row_nxt       = '0;
        w_col_nxt       = '0;
        w_done_nxt      = 1'b0;
        w_hit_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ref_pending) begin
                    w_cmd_valid_nxt = 1'b1;
                    if (|r_tbl_valid) begin
                        w_cmd_nxt   = c_CMD_PREA;
                        w_state_nxt = PREA;
                        w_timer_nxt = c_TIM_W'(T_RP - 1);
                    end else begin
                        w_cmd_nxt   = c_CMD_REF;
                        w_tbl_clr   = 1'b1;
                        w_state_nxt = REF;
                        w_timer_nxt = c_TIM_W'(T_RFC - 1);
                    end
                end else if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (req_op == 2'd3) begin
                        w_done_nxt = 1'b1;
                    end else if (w_req_hit) begin
                        if (w_ccd_ok) w_col_go = 1'b1;
                        else          w_state_nxt = COL;
                    end else if (r_tbl_valid[w_req_idx]) begin
                        w_cmd_valid_nxt = 1'b1;
                        w_cmd_nxt       = c_CMD_PRE;
                        w_bg_nxt        = w_req_bg;
                        w_ba_nxt        = w_req_ba;
                        w_state_nxt     = PRE;
                        w_timer_nxt     = c_TIM_W'(T_RP - 1);
                    end else begin
                        w_act_go = 1'b1;
                    end
                end
            end
            PRE:  if (r_timer == '0) w_act_go = 1'b1;
            ACT: begin
                if (r_timer == '0) begin
                    if (w_ccd_ok) w_col_go = 1'b1;
                    else          w_state_nxt = COL;
                end
            end
            COL:  if (w_ccd_ok) w_col_go = 1'b1;
            DATA: begin
                if (r_timer == '0) begin
                    w_done_nxt  = 1'b1;
                    w_hit_nxt   = r_hit;
                    w_state_nxt = IDLE;
                end
            end
            PREA: begin
                if (r_timer == '0) begin
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_nxt       = c_CMD_REF;
                    w_tbl_clr       = 1'b1;
                    w_state_nxt     = REF;
                    w_timer_nxt     = c_TIM_W'(T_RFC - 1);
                end
            end
            REF: begin
                if (r_timer == '0) begin
                    w_ref_clear = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_act_go) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt       = c_CMD_ACT;
            w_bg_nxt        = w_cur_bg;
            w_ba_nxt        = w_cur_ba;
            w_row_nxt       = w_cur_row;
            w_state_nxt     = ACT;
            w_timer_nxt     = c_TIM_W'(T_RCD - 1);
        end
        if (w_col_go) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt       = w_cur_rd ? c_CMD_RD : c_CMD_WR;
            w_bg_nxt        = w_cur_bg;
            w_ba_nxt        = w_cur_ba;
            w_col_nxt       = w_cur_col;
            w_state_nxt     = DATA;
            w_timer_nxt     = w_cur_rd ? c_TIM_W'(T_CL + T_BURST - 1)
                                       : c_TIM_W'(T_CWL + T_BURST - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer       <= '0;
            r_refi_cnt    <= '0;
            r_ref_pending <= 1'b0;
            r_ccd_cnt     <= 8'hFF;
            r_last_bg     <= '0;
            r_tbl_valid   <= '0;
            r_op          <= '0;
            r_bg          <= '0;
            r_ba          <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_hit         <= 1'b0;
            r_req_ready   <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd         <= c_CMD_NOP;
            r_cmd_bg      <= '0;
            r_cmd_ba      <= '0;
            r_cmd_row     <= '0;
            r_cmd_col     <= '0;
            r_done        <= 1'b0;
            r_page_hit    <= 1'b0;
        end else begin
            r_timer       <= w_timer_nxt;
            r_refi_cnt    <= w_expire ? '0 : r_refi_cnt + 1'b1;
            r_ref_pending <= w_pend_nxt;
            if (w_col_go) begin
                r_ccd_cnt <= '0;
                r_last_bg <= w_cur_bg;
            end else if (r_ccd_cnt != 8'hFF) begin
                r_ccd_cnt <= r_ccd_cnt + 1'b1;
            end
            if (w_tbl_clr)     r_tbl_valid            <= '0;
            else if (w_act_go) r_tbl_valid[w_cur_idx] <= 1'b1;
            if (w_accept) begin
                r_op  <= req_op;
                r_bg  <= w_req_bg;
                r_ba  <= w_req_ba;
                r_row <= w_req_row;
                r_col <= w_req_col;
                r_hit <= w_req_hit;
            end
            r_req_ready <= w_ready_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_bg    <= w_bg_nxt;
            r_cmd_ba    <= w_ba_nxt;
            r_cmd_row   <= w_row_nxt;
            r_cmd_col   <= w_col_nxt;
            r_done      <= w_done_nxt;
            r_page_hit  <= w_hit_nxt;
        end
    end

    // Row contents are only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (w_act_go) r_tbl_row[w_cur_idx] <= w_cur_row;
    end

    assign req_ready = r_req_ready;
    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd;
    assign cmd_bg    = r_cmd_bg;
    assign cmd_ba    = r_cmd_ba;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign done      = r_done;
    assign page_hit  = r_page_hit;

endmodule
`default_nettype wire
